// File: rtl/mem_write_checker.sv
// mem_write_checker: watches the data-memory write bus against N_WATCH programmable
// (address, expected data) entries and reports sticky pass/fail/timeout status.
// Optional macro WCHK_ORDERED_EN: entries must be hit in ascending index order.
module mem_write_checker #(
   parameter int  N_WATCH = 4,
   parameter int  ADDR_W  = 32,
   parameter int  DATA_W  = 32,
   parameter int  CNT_W   = 24,
   localparam int IDX_W   = (N_WATCH > 1) ? $clog2(N_WATCH) : 1
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic              start,
   input  logic              clear,
   input  logic [CNT_W-1:0]  timeout_limit,
   output logic              busy,
   output logic              success,
   output logic              fail,
   output logic              timeout,
   output logic [N_WATCH-1:0] hit_mask,
   output logic [CNT_W-1:0]  cycles,
   output logic [IDX_W-1:0]  fail_idx,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data
);

   // start, clear and cfg_we are single-cycle strobes sampled on the rising edge;
   // there is no back-pressure, so every strobe is either honoured or dropped that cycle.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_TIMEOUT = 3'd4
   } state_t;

   localparam logic [IDX_W:0] N_LIM = (IDX_W+1)'(N_WATCH);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ent_addr_q [N_WATCH];
   logic [DATA_W-1:0]   ent_data_q [N_WATCH];
   logic [N_WATCH-1:0]  ent_valid_q, ent_valid_d;
   logic [N_WATCH-1:0]  hit_q, hit_d;
   logic [CNT_W-1:0]    cycles_q, cycles_d;
   logic [IDX_W-1:0]    fail_idx_q, fail_idx_d;
   logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
   logic [DATA_W-1:0]   fail_data_q, fail_data_d;

   logic                cfg_wr;
   logic [N_WATCH-1:0]  match_v, good_v, bad_v, order_err_v, fail_v, new_hits;
   logic [IDX_W-1:0]    fail_sel;
   logic [CNT_W-1:0]    cycles_inc;
   logic                all_hit, tmo_hit;

   assign cfg_wr = (state_q == S_IDLE) && cfg_we && ({1'b0, cfg_idx} < N_LIM);

   always_comb begin
      match_v = '0;
      good_v  = '0;
      bad_v   = '0;
      for (int i = 0; i < N_WATCH; i++) begin
         match_v[i] = mem_we && ent_valid_q[i] && (ent_addr_q[i] == mem_addr);
         good_v[i]  = match_v[i] && (ent_data_q[i] == mem_wdata);
         bad_v[i]   = match_v[i] && (ent_data_q[i] != mem_wdata);
      end
   end

`ifdef WCHK_ORDERED_EN
   // A lower entry satisfied by this same write counts as already hit.
   logic lower_open;
   always_comb begin
      order_err_v = '0;
      lower_open  = 1'b0;
      for (int i = 0; i < N_WATCH; i++) begin
         if (good_v[i] && lower_open) order_err_v[i] = 1'b1;
         if (ent_valid_q[i] && !hit_q[i] && !good_v[i]) lower_open = 1'b1;
      end
   end
`else
   assign order_err_v = '0;
`endif

   assign fail_v = bad_v | order_err_v;

   always_comb begin
      fail_sel = '0;
      for (int i = N_WATCH - 1; i >= 0; i--) begin
         if (fail_v[i]) fail_sel = IDX_W'(i);
      end
   end

   assign new_hits   = hit_q | good_v;
   assign all_hit    = ((new_hits & ent_valid_q) == ent_valid_q);
   assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
   assign tmo_hit    = (timeout_limit != '0) && (cycles_inc == timeout_limit);

   always_comb begin
      state_d     = state_q;
      hit_d       = hit_q;
      cycles_d    = cycles_q;
      fail_idx_d  = fail_idx_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      ent_valid_d = ent_valid_q;
      if (cfg_wr) ent_valid_d[cfg_idx] = 1'b1;
      case (state_q)
         S_IDLE: begin
            // The arming check sees an entry written in this same cycle.
            if (start && (|ent_valid_d)) begin
               state_d     = S_ARMED;
               hit_d       = '0;
               cycles_d    = '0;
               fail_idx_d  = '0;
               fail_addr_d = '0;
               fail_data_d = '0;
            end
         end
         S_ARMED: begin
            cycles_d = cycles_inc;
            if (|fail_v) begin
               state_d     = S_FAIL;
               fail_idx_d  = fail_sel;
               fail_addr_d = mem_addr;
               fail_data_d = mem_wdata;
            end else begin
               hit_d = new_hits;
               if (all_hit)      state_d = S_PASS;
               else if (tmo_hit) state_d = S_TIMEOUT;
            end
         end
         S_PASS, S_FAIL, S_TIMEOUT: begin
            // Leaving a terminal state wipes the run results; entries stay programmed.
            if (clear) begin
               state_d     = S_IDLE;
               hit_d       = '0;
               cycles_d    = '0;
               fail_idx_d  = '0;
               fail_addr_d = '0;
               fail_data_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ent_valid_q <= '0;
         hit_q       <= '0;
         cycles_q    <= '0;
         fail_idx_q  <= '0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
      end else begin
         state_q     <= state_d;
         ent_valid_q <= ent_valid_d;
         hit_q       <= hit_d;
         cycles_q    <= cycles_d;
         fail_idx_q  <= fail_idx_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_WATCH; i++) begin
            ent_addr_q[i] <= '0;
            ent_data_q[i] <= '0;
         end
      end else if (cfg_wr) begin
         ent_addr_q[cfg_idx] <= cfg_addr;
         ent_data_q[cfg_idx] <= cfg_data;
      end
   end

   assign busy      = (state_q == S_ARMED);
   assign success   = (state_q == S_PASS);
   assign fail      = (state_q == S_FAIL) || (state_q == S_TIMEOUT);
   assign timeout   = (state_q == S_TIMEOUT);
   assign hit_mask  = hit_q;
   assign cycles    = cycles_q;
   assign fail_idx  = fail_idx_q;
   assign fail_addr = fail_addr_q;
   assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus randomized traffic, all outputs
// compared every cycle against an entry-list reference model.
module tb_mem_write_checker;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int CW = 24;
   localparam int IW = 2;
   localparam longint CMAX = (64'd1 << CW) - 1;

   localparam int M_IDLE = 0, M_ARMED = 1, M_PASS = 2, M_FAIL = 3, M_TMO = 4;

   logic          sysclk = 1'b0;
   logic          reset;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          cfg_we;
   logic [IW-1:0] cfg_idx;
   logic [AW-1:0] cfg_addr;
   logic [DW-1:0] cfg_data;
   logic          start;
   logic          clear;
   logic [CW-1:0] timeout_limit;
   logic          busy, success, fail, timeout;
   logic [N-1:0]  hit_mask;
   logic [CW-1:0] cycles;
   logic [IW-1:0] fail_idx;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_data;

   int n_checks = 0;
   int n_errors = 0;

   mem_write_checker #(.N_WATCH(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .sysclk(sysclk), .reset(reset),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .start(start), .clear(clear), .timeout_limit(timeout_limit),
      .busy(busy), .success(success), .fail(fail), .timeout(timeout),
      .hit_mask(hit_mask), .cycles(cycles),
      .fail_idx(fail_idx), .fail_addr(fail_addr), .fail_data(fail_data)
   );

   // clock / watchdog
   always #5 sysclk = ~sysclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model: list of entries plus run outcome
   int            m_state;
   logic [AW-1:0] m_addr [N];
   logic [DW-1:0] m_data [N];
   bit            m_valid [N];
   bit            m_hit [N];
   longint        m_cycles;
   int            m_fidx;
   logic [AW-1:0] m_faddr;
   logic [DW-1:0] m_fdata;

   function automatic void model_clear_run();
      for (int i = 0; i < N; i++) m_hit[i] = 0;
      m_cycles = 0;
      m_fidx   = 0;
      m_faddr  = '0;
      m_fdata  = '0;
   endfunction

   function automatic void model_reset();
      m_state = M_IDLE;
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0;
         m_addr[i]  = '0;
         m_data[i]  = '0;
      end
      model_clear_run();
   endfunction

   function automatic void model_step();
      bit     any_valid;
      bit     good [N];
      bit     all_done;
      int     fi;
      longint cyc;
      case (m_state)
         M_IDLE: begin
            if (cfg_we && int'(cfg_idx) < N) begin
               m_addr[cfg_idx]  = cfg_addr;
               m_data[cfg_idx]  = cfg_data;
               m_valid[cfg_idx] = 1;
            end
            any_valid = 0;
            for (int i = 0; i < N; i++) any_valid |= m_valid[i];
            if (start && any_valid) begin
               m_state = M_ARMED;
               model_clear_run();
            end
         end
         M_ARMED: begin
            cyc = (m_cycles + 1 > CMAX) ? CMAX : m_cycles + 1;
            m_cycles = cyc;
            fi = -1;
            for (int i = 0; i < N; i++) begin
               good[i] = 0;
               if (mem_we && m_valid[i] && m_addr[i] == mem_addr) begin
                  if (m_data[i] == mem_wdata) begin
                     good[i] = 1;
`ifdef WCHK_ORDERED_EN
                     for (int j = 0; j < i; j++)
                        if (m_valid[j] && !m_hit[j] && !good[j] && fi < 0) fi = i;
`endif
                  end else if (fi < 0) begin
                     fi = i;
                  end
               end
            end
            if (fi >= 0) begin
               m_state = M_FAIL;
               m_fidx  = fi;
               m_faddr = mem_addr;
               m_fdata = mem_wdata;
            end else begin
               all_done = 1;
               for (int i = 0; i < N; i++) begin
                  m_hit[i] |= good[i];
                  if (m_valid[i] && !m_hit[i]) all_done = 0;
               end
               if (all_done) m_state = M_PASS;
               else if (timeout_limit != 0 && cyc == longint'(timeout_limit)) m_state = M_TMO;
            end
         end
         default: begin
            if (clear) begin
               m_state = M_IDLE;
               model_clear_run();
            end
         end
      endcase
   endfunction

   // checking
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all(input string tag);
      logic [N-1:0] hm;
      for (int i = 0; i < N; i++) hm[i] = m_hit[i];
      check({tag, "_busy"},    busy,      m_state == M_ARMED);
      check({tag, "_success"}, success,   m_state == M_PASS);
      check({tag, "_fail"},    fail,      m_state == M_FAIL || m_state == M_TMO);
      check({tag, "_timeout"}, timeout,   m_state == M_TMO);
      check({tag, "_hit"},     hit_mask,  hm);
      check({tag, "_cycles"},  cycles,    m_cycles);
      check({tag, "_fidx"},    fail_idx,  m_fidx);
      check({tag, "_faddr"},   fail_addr, m_faddr);
      check({tag, "_fdata"},   fail_data, m_fdata);
   endtask

   // driver tasks: inputs change 1 time unit after the rising edge
   task automatic step();
      model_step();
      @(posedge sysclk);
      #1;
      compare_all("cyc");
      mem_we = 0; cfg_we = 0; start = 0; clear = 0;
   endtask

   task automatic hard_reset();
      reset = 1;
      @(posedge sysclk);
      #1;
      reset = 0;
      model_reset();
      compare_all("rst");
   endtask

   task automatic drv_cfg(input int idx, input int a, input int d);
      cfg_we = 1; cfg_idx = IW'(idx); cfg_addr = AW'(a); cfg_data = DW'(d);
      step();
   endtask

   task automatic drv_start();
      start = 1;
      step();
   endtask

   task automatic drv_clear();
      clear = 1;
      step();
   endtask

   task automatic drv_wr(input int a, input int d);
      mem_we = 1; mem_addr = AW'(a); mem_wdata = DW'(d);
      step();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int pool_a [5];
      int pool_d [3];
      reset = 1; mem_we = 0; mem_addr = '0; mem_wdata = '0;
      cfg_we = 0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
      start = 0; clear = 0; timeout_limit = '0;
      pool_a = '{100, 104, 108, 112, 200};
      pool_d = '{25, 7, 9};

      // reset state
      @(posedge sysclk); @(posedge sysclk); #1;
      model_reset();
      compare_all("reset");
      reset = 0;

      // single entry pass
      drv_cfg(0, 100, 25);
      drv_start();
      drv_wr(100, 25);
      check("tp1_success", success, 1);
      check("tp1_fail", fail, 0);
      check("tp1_busy", busy, 0);
      check("tp1_hit", hit_mask, 4'b0001);

      // data mismatch, then clear and re-arm from retained entry
      hard_reset();
      drv_cfg(0, 100, 25);
      drv_start();
      drv_wr(100, 24);
      check("tp2_fail", fail, 1);
      check("tp2_timeout", timeout, 0);
      check("tp2_fidx", fail_idx, 0);
      check("tp2_faddr", fail_addr, 100);
      check("tp2_fdata", fail_data, 24);
      drv_start();
      check("tp2_start_in_fail", fail, 1);
      drv_clear();
      check("tp2_clr_status", {busy, success, fail, timeout}, 4'b0000);
      drv_start();
      check("tp2_rearm", busy, 1);
      drv_wr(100, 25);
      check("tp2_pass", success, 1);

      // timeout, then resolution on the limit cycle beats timeout
      hard_reset();
      timeout_limit = 10;
      drv_cfg(0, 100, 25);
      drv_start();
      idle_cycles(10);
      check("tp3_timeout", timeout, 1);
      check("tp3_fail", fail, 1);
      check("tp3_cycles", cycles, 10);
      drv_clear();
      drv_start();
      idle_cycles(9);
      drv_wr(100, 25);
      check("tp3_success", success, 1);
      check("tp3_no_timeout", timeout, 0);
      timeout_limit = 0;

      // two entries, second hit first
      hard_reset();
      drv_cfg(0, 100, 25);
      drv_cfg(1, 104, 7);
      drv_start();
      drv_wr(200, 5);
      drv_wr(104, 7);
`ifdef WCHK_ORDERED_EN
      check("tp4_ord_fail", fail, 1);
      check("tp4_ord_fidx", fail_idx, 1);
`else
      check("tp4_busy", busy, 1);
      check("tp4_hit", hit_mask, 4'b0010);
      drv_wr(100, 25);
      check("tp4_success", success, 1);
      check("tp4_hit_all", hit_mask, 4'b0011);
`endif

      // async reset mid-run, then start with no entries is ignored
      hard_reset();
      drv_cfg(0, 100, 25);
      drv_cfg(1, 104, 7);
      drv_start();
      drv_wr(100, 25);
      #2 reset = 1;
      #1;
      check("tp5_async_busy", busy, 0);
      check("tp5_async_hit", hit_mask, 0);
      check("tp5_async_cycles", cycles, 0);
      model_reset();
      @(posedge sysclk); #1;
      reset = 0;
      compare_all("tp5_rst");
      drv_start();
      check("tp5_start_ignored", busy, 0);

      // cfg and start in the same cycle; cfg while armed is ignored
      cfg_we = 1; cfg_idx = 2; cfg_addr = 300; cfg_data = 9;
      drv_start();
      check("cfg_start_busy", busy, 1);
      drv_cfg(3, 400, 1);
      drv_wr(400, 1);
      check("cfg_armed_ignored", busy, 1);
      drv_wr(300, 9);
      check("cfg_start_pass", success, 1);

      // duplicate address with different data always fails at the lower mismatch
      hard_reset();
      drv_cfg(0, 100, 1);
      drv_cfg(1, 100, 2);
      drv_start();
      drv_wr(100, 1);
      check("dup_fail", fail, 1);
      check("dup_fidx", fail_idx, 1);
      drv_clear();

      // randomized traffic, every cycle compared against the model
      for (int run = 0; run < 40; run++) begin
         if ($urandom_range(0, 3) == 0) hard_reset();
         timeout_limit = ($urandom_range(0, 1) == 0) ? CW'(0) : CW'($urandom_range(3, 25));
         for (int k = 0; k < int'($urandom_range(1, 4)); k++)
            drv_cfg($urandom_range(0, N - 1), pool_a[$urandom_range(0, 3)], pool_d[$urandom_range(0, 2)]);
         drv_start();
         for (int c = 0; c < 30; c++) begin
            mem_we    = ($urandom_range(0, 2) != 0);
            mem_addr  = AW'(pool_a[$urandom_range(0, 4)]);
            mem_wdata = DW'(pool_d[$urandom_range(0, 2)]);
            start     = ($urandom_range(0, 15) == 0);
            clear     = ($urandom_range(0, 15) == 0);
            cfg_we    = ($urandom_range(0, 15) == 0);
            cfg_idx   = IW'($urandom_range(0, N - 1));
            cfg_addr  = AW'(pool_a[$urandom_range(0, 3)]);
            cfg_data  = DW'(pool_d[$urandom_range(0, 2)]);
            step();
         end
         drv_clear();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
Parametrised successor to the single-address success/fail write monitor on the core's data-memory port. Watches the post-boundary-scan memory write bus (MemWriteM/DataAdrM/WriteDataM) against N_WATCH programmable (address, expected data) entries. Reports sticky pass/fail/timeout status, a hit mask, a cycle count and a first-failure capture. Sits beside the RISC-V core in the JTAG top and is clocked by sysclk.

Parameters:
N_WATCH, 4, number of watch entries (1..16)
ADDR_W, 32, write address width
DATA_W, 32, write data width
CNT_W, 24, cycle counter / timeout limit width

Ports:
sysclk  input  1  clock, all state on rising edge
reset  input  1  reset, asynchronous, active-high
mem_we  input  1  memory write strobe (MemWriteM)
mem_addr  input  ADDR_W  write address
mem_wdata  input  DATA_W  write data
cfg_we  input  1  program watch entry (honoured in IDLE only)
cfg_idx  input  $clog2(N_WATCH) (min 1)  entry index
cfg_addr  input  ADDR_W  entry address
cfg_data  input  DATA_W  entry expected data
start  input  1  pulse: arm checker
clear  input  1  pulse: return to IDLE from terminal state
timeout_limit  input  CNT_W  0 = no timeout
busy  output  1  state == ARMED
success  output  1  state == PASS
fail  output  1  state == FAIL or TIMEOUT
timeout  output  1  state == TIMEOUT
hit_mask  output  N_WATCH  entries satisfied this run
cycles  output  CNT_W  cycles spent in ARMED, saturating
fail_idx  output  $clog2(N_WATCH) (min 1)  entry that failed
fail_addr  output  ADDR_W  captured failing address
fail_data  output  DATA_W  captured failing data

Behaviour:
- Reset: state IDLE; all entries invalid; every output 0 (hit_mask, cycles, fail_* all zero).
- States: IDLE, ARMED, PASS, FAIL, TIMEOUT. All outputs registered; status changes are visible the cycle after the triggering edge.
- IDLE:
  - cfg_we writes entry cfg_idx (addr, data, valid=1).
  - cfg_idx >= N_WATCH: write ignored.
  - cfg_we in any state other than IDLE: ignored.
  - start with >=1 valid entry: go to ARMED; clear hit_mask, cycles and fail_*.
  - start with no valid entry: ignored, stay IDLE.
  - cfg_we and start in the same cycle: the cfg write takes effect, and the valid check for start includes the newly written entry.
- ARMED, each cycle:
  - cycles increments, saturating at all-ones.
  - If mem_we: every valid entry with addr == mem_addr is compared.
    - Data equal: set hit[i].
    - Any valid matching entry with unequal data: go to FAIL. Capture mem_addr, mem_wdata, and the lowest mismatching index into fail_*.
    - Fail has priority over hits in the same write.
    - Duplicate addresses with different expected data therefore always fail.
  - Writes to unwatched addresses are ignored.
  - Re-hitting an already-hit entry with correct data is harmless.
  - Re-hitting an already-hit entry with wrong data goes to FAIL.
  - When (hit_mask | new hits) covers all valid entries: go to PASS.
  - Timeout: if timeout_limit != 0 and the incremented cycles == timeout_limit with no PASS/FAIL resolution that cycle, go to TIMEOUT. fail_idx/addr/data stay 0.
  - Resolution by a write in that same cycle beats timeout.
- PASS / FAIL / TIMEOUT: sticky. Status, hit_mask, cycles and fail_* hold.
  - start ignored.
  - clear goes to IDLE and zeroes status outputs; entries are retained.
  - clear in IDLE or ARMED: no effect.
- Reset mid-run: immediate return to IDLE with all entries invalidated.
- Equality is exact bitwise; X/Z on the inputs is not a supported input.

Optional Feature:
Macro: WCHK_ORDERED_EN
- Defined: valid entries must be hit in ascending index order. A correct-data write to entry j while any lower-index valid entry is unhit goes to FAIL, with fail_idx=j and the write's addr/data captured. Invalid (unprogrammed) lower entries are skipped.
- Undefined: entries may be hit in any order; no ordering logic is synthesised.

Test Plan:
- Program entry0=(100,25), start, write (100,25) -> next cycle success=1, fail=0, busy=0, hit_mask=0001.
- Entry0=(100,25), start, write (100,24) -> fail=1, timeout=0, fail_idx=0, fail_addr=100, fail_data=24. Then clear -> all status 0 and entry0 still valid (start re-arms).
- Entry0=(100,25), timeout_limit=10, start, no writes -> timeout=1 and fail=1 with cycles=10. Repeat with write (100,25) on the 10th ARMED cycle -> success=1, timeout=0.
- Entries 0=(100,25), 1=(104,7):
  - writes (200,5) then (104,7) -> busy=1, hit_mask=0010.
  - then (100,25) -> success=1, hit_mask=0011.
- Reset asserted mid-ARMED after one hit -> outputs all 0 asynchronously. A following start without cfg_we is ignored (busy stays 0).
- Entries 0=(100,25), 1=(104,7), write (104,7) first:
  - with WCHK_ORDERED_EN -> fail=1, fail_idx=1.
  - without it -> busy=1; then (100,25) -> success=1.
